// File: rtl/axi_line_refill_bridge_if.sv
// Bus bundles around the line refill bridge: the cache-side refill request/return
// channel and the AXI4 read-address/read-data channels toward the interconnect.
interface line_req_if #(
  parameter int LINE_WORDS = 4
);
  logic                       rd_req;
  logic [31:0]                rd_addr;
  logic                       rd_rdy;
  logic                       ret_valid;
  logic [32*LINE_WORDS-1:0]   ret_data;

  modport master (output rd_req, rd_addr, input rd_rdy, ret_valid, ret_data);
  modport slave  (input rd_req, rd_addr, output rd_rdy, ret_valid, ret_data);
endinterface

interface axi_rd_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, arlen, arsize, arburst, arvalid, rready,
                  input arready, rdata, rlast, rvalid);
  modport slave  (input araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rdata, rlast, rvalid);
endinterface

// File: rtl/axi_line_refill_bridge.sv
// Turns one cache-line refill request into a single AXI4 INCR read burst and
// returns the assembled line to the cache as a one-cycle ret_valid pulse.
module axi_line_refill_bridge #(
  parameter int LINE_WORDS  = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  line_req_if.slave      cache,
  axi_rd_if.master       axi
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [LINE_WORDS-1:0][31:0]     line_buf;
  logic [LINE_WORDS-1:0][31:0]     line_next;
  logic                            beat;
  logic                            burst_done;
  logic                            unused_offset;

  assign unused_offset = ^cache.rd_addr[OFFSET_BITS-1:0];

  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;

  assign cache.rd_rdy = (state == IDLE) && !rst;

  assign beat       = (state == R) && axi.rvalid && axi.rready;
  assign burst_done = beat && ((cnt == CNT_W'(LINE_WORDS - 1)) || axi.rlast);

  // Line as it will look after the current beat; words past the current beat
  // read as zero so a burst cut short by rlast never leaks a previous line.
  always_comb begin
    line_next = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (CNT_W'(i) < cnt)
        line_next[i] = line_buf[i];
      else if (CNT_W'(i) == cnt)
        line_next[i] = axi.rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      line_buf        <= '0;
      axi.araddr      <= '0;
      axi.arvalid     <= 1'b0;
      axi.rready      <= 1'b0;
      cache.ret_valid <= 1'b0;
      cache.ret_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cache.rd_req) begin
            axi.araddr  <= {cache.rd_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt         <= '0;
            axi.arvalid <= 1'b1;
            state       <= AR;
          end
        end
        AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= R;
          end
        end
        R: begin
          if (beat) begin
            line_buf[cnt] <= axi.rdata;
            cnt           <= cnt + 1'b1;
          end
          // ret_data is loaded together with the last beat so it is already
          // valid during the single RET cycle.
          if (burst_done) begin
            axi.rready      <= 1'b0;
            cache.ret_valid <= 1'b1;
            cache.ret_data  <= line_next;
            state           <= RET;
          end
        end
        RET: begin
          cache.ret_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_refill_bridge.sv
// Directed bench for axi_line_refill_bridge: drives the cache request side and
// plays a hand-scripted AXI slave, comparing against hand-computed lines.
module tb_axi_line_refill_bridge;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  line_req_if #(.LINE_WORDS(4)) cache_if ();
  axi_rd_if                     axi_if ();

  axi_line_refill_bridge #(
    .LINE_WORDS  (4),
    .OFFSET_BITS (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cache (cache_if),
    .axi   (axi_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic arready, input logic rvalid,
                               input logic [31:0] rdata, input logic rlast);
    cache_if.rd_req  = req;
    cache_if.rd_addr = addr;
    axi_if.arready   = arready;
    axi_if.rvalid    = rvalid;
    axi_if.rdata     = rdata;
    axi_if.rlast     = rlast;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete refill: request at cycle T, arWait cycles of AR backpressure,
  // then the rvalid pattern (bit p = cycle p of the R phase); ret_valid must
  // appear exactly on the cycle after the last pattern cycle.
  task automatic runFill(input string name, input logic [31:0] addr,
                         input logic [31:0] expAddr, input int arWait,
                         input logic [15:0] pattern, input int patLen,
                         input logic [3:0][31:0] words, input int nBeats,
                         input bit useRlast, input bit holdReq,
                         input logic [127:0] expLine);
    int beatIdx;
    checkOutput({name, "_rdy_idle"}, cache_if.rd_rdy, 1'b1);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    if (!holdReq) cache_if.rd_req = 1'b0;
    for (int k = 0; k < arWait; k++) begin
      checkOutput({name, "_arvalid_wait"}, axi_if.arvalid, 1'b1);
      checkOutput({name, "_araddr_wait"}, axi_if.araddr, expAddr);
      tick;
    end
    axi_if.arready = 1'b1;
    checkOutput({name, "_arvalid"}, axi_if.arvalid, 1'b1);
    checkOutput({name, "_araddr"}, axi_if.araddr, expAddr);
    checkOutput({name, "_arlen"}, axi_if.arlen, 8'd3);
    checkOutput({name, "_arsize"}, axi_if.arsize, 3'd2);
    checkOutput({name, "_arburst"}, axi_if.arburst, 2'd1);
    checkOutput({name, "_rdy_busy"}, cache_if.rd_rdy, 1'b0);
    tick;
    axi_if.arready = 1'b0;
    checkOutput({name, "_arvalid_drop"}, axi_if.arvalid, 1'b0);
    beatIdx = 0;
    for (int p = 0; p < patLen; p++) begin
      if (pattern[p]) begin
        axi_if.rvalid = 1'b1;
        axi_if.rdata  = words[beatIdx];
        axi_if.rlast  = useRlast && (beatIdx == nBeats - 1);
        beatIdx++;
      end else begin
        axi_if.rvalid = 1'b0;
        axi_if.rdata  = 32'hDEADBEEF;
        axi_if.rlast  = 1'b0;
      end
      checkOutput({name, "_rready"}, axi_if.rready, 1'b1);
      checkOutput({name, "_ret_early"}, cache_if.ret_valid, 1'b0);
      checkOutput({name, "_rdy_in_r"}, cache_if.rd_rdy, 1'b0);
      tick;
    end
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    checkOutput({name, "_ret_valid"}, cache_if.ret_valid, 1'b1);
    checkOutput({name, "_ret_data"}, cache_if.ret_data, expLine);
    checkOutput({name, "_rready_off"}, axi_if.rready, 1'b0);
    checkOutput({name, "_rdy_ret"}, cache_if.rd_rdy, 1'b0);
    tick;
    checkOutput({name, "_ret_pulse"}, cache_if.ret_valid, 1'b0);
    checkOutput({name, "_rdy_back"}, cache_if.rd_rdy, 1'b1);
    checkOutput({name, "_ret_hold"}, cache_if.ret_data, expLine);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    tick;
    checkOutput("rst_rdy", cache_if.rd_rdy, 1'b0);
    checkOutput("rst_arvalid", axi_if.arvalid, 1'b0);
    checkOutput("rst_rready", axi_if.rready, 1'b0);
    checkOutput("rst_ret_valid", cache_if.ret_valid, 1'b0);
    checkOutput("rst_ret_data", cache_if.ret_data, 128'h0);
    checkOutput("rst_araddr", axi_if.araddr, 32'h0);
    rst = 1'b0;
    tick;
    checkOutput("rst_release_rdy", cache_if.rd_rdy, 1'b1);

    runFill("basic", 32'h1FC0_0014, 32'h1FC0_0010, 0, 16'b1111, 4,
            {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, 1'b1, 1'b0,
            128'h000000A3_000000A2_000000A1_000000A0);

    runFill("ar_bp", 32'h2000_0028, 32'h2000_0020, 5, 16'b1111, 4,
            {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4, 1'b1, 1'b0,
            128'h000000C3_000000C2_000000C1_000000C0);

    // Completion here relies on the beat counter alone: rlast is never raised.
    runFill("r_gaps", 32'h3000_003C, 32'h3000_0030, 0, 16'b1011001, 7,
            {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4, 1'b0, 1'b0,
            128'h000000B3_000000B2_000000B1_000000B0);

    runFill("short", 32'h4000_0008, 32'h4000_0000, 0, 16'b11, 2,
            {32'h0, 32'h0, 32'h22, 32'h11}, 2, 1'b1, 1'b0,
            128'h00000000_00000000_00000022_00000011);

    runFill("b2b_a", 32'h5000_0000, 32'h5000_0000, 0, 16'b1111, 4,
            {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4, 1'b1, 1'b1,
            128'h000000D3_000000D2_000000D1_000000D0);
    runFill("b2b_b", 32'h5000_0010, 32'h5000_0010, 0, 16'b1111, 4,
            {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4, 1'b1, 1'b0,
            128'h000000E3_000000E2_000000E1_000000E0);

    applyStimulus(1'b1, 32'h6000_0044, 1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    cache_if.rd_req = 1'b0;
    axi_if.arready  = 1'b1;
    tick;
    axi_if.arready = 1'b0;
    checkOutput("abort_rready", axi_if.rready, 1'b1);
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'hF0;
    tick;
    axi_if.rdata = 32'hF1;
    tick;
    axi_if.rdata = 32'hF2;
    rst = 1'b1;
    #1;
    checkOutput("abort_arvalid", axi_if.arvalid, 1'b0);
    checkOutput("abort_rready_drop", axi_if.rready, 1'b0);
    checkOutput("abort_ret_valid", cache_if.ret_valid, 1'b0);
    checkOutput("abort_rdy", cache_if.rd_rdy, 1'b0);
    checkOutput("abort_ret_data", cache_if.ret_data, 128'h0);
    tick;
    checkOutput("abort_no_ret", cache_if.ret_valid, 1'b0);
    axi_if.rvalid = 1'b0;
    rst = 1'b0;
    tick;
    checkOutput("abort_release_rdy", cache_if.rd_rdy, 1'b1);
    checkOutput("abort_release_ret", cache_if.ret_valid, 1'b0);

    runFill("recover", 32'h7000_0004, 32'h7000_0000, 0, 16'b1111, 4,
            {32'h73, 32'h72, 32'h71, 32'h70}, 4, 1'b1, 1'b0,
            128'h00000073_00000072_00000071_00000070);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
